// File: rtl/pong_pkg.sv
// Shared constants, types and helpers for the pong board logic.
package pong_pkg;

    localparam int CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {REL, DELAY, REPT} rep_state_t;

    function automatic int ms_to_cycles(int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, counter debounce, press/release pulses.
// Auto-repeat of btn_press while held is built only when BTN_REPEAT_EN is defined.
module btn_chan
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef BTN_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
`endif
) (
    input  logic clk_50M,
    input  logic rst_b,
    input  logic btn_b,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Sync flops hold the raw active-low value, so reset to 1 means released.
    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    logic          accept;

    assign s      = ~sync[1];
    assign accept = (s != btn_level) && (cnt == CNT_LAST);

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    rep_state_t    state;
    logic [RW-1:0] rcnt;
    logic          rep_fire;

    assign rep_fire = ((state == DELAY) && (rcnt == DLY_LAST)) ||
                      ((state == REPT)  && (rcnt == PER_LAST));

    // Release wins over everything, including a repeat due in the same cycle.
    always_ff @(posedge clk_50M or negedge rst_b) begin
        if (!rst_b) begin
            state <= REL;
            rcnt  <= '0;
        end else if (accept && !s) begin
            state <= REL;
            rcnt  <= '0;
        end else begin
            case (state)
                REL: begin
                    if (accept && s) begin
                        state <= DELAY;
                        rcnt  <= '0;
                    end
                end
                DELAY: begin
                    if (rcnt == DLY_LAST) begin
                        state <= REPT;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                REPT: begin
                    if (rcnt == PER_LAST) rcnt <= '0;
                    else                  rcnt <= rcnt + RW'(1);
                end
                default: begin
                    state <= REL;
                    rcnt  <= '0;
                end
            endcase
        end
    end
`endif

    always_ff @(posedge clk_50M or negedge rst_b) begin
        if (!rst_b) begin
            sync        <= 2'b11;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync <= {sync[0], btn_b};
            if (s == btn_level) begin
                cnt <= '0;
            end else if (accept) begin
                btn_level <= s;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            btn_release <= accept & ~s;
`ifdef BTN_REPEAT_EN
            btn_press   <= (accept & s) | (rep_fire & ~(accept & ~s));
`else
            btn_press   <= accept & s;
`endif
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: fans the button buses out to btn_chan instances.
// Define BTN_REPEAT_EN to build auto-repeat of btn_press while a button is held.
module btn_conditioner
    import pong_pkg::*;
#(
    parameter int N_BTNS          = 4,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(20),
    parameter int REPEAT_DELAY    = ms_to_cycles(500),
    parameter int REPEAT_PERIOD   = ms_to_cycles(100)
) (
    input  logic              clk_50M,
    input  logic              rst_b,
    input  logic [N_BTNS-1:0] btns_b,
    output logic [N_BTNS-1:0] btn_level,
    output logic [N_BTNS-1:0] btn_press,
    output logic [N_BTNS-1:0] btn_release
);

`ifndef BTN_REPEAT_EN
    // Repeat timing has no effect in this build; keep it referenced.
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    for (genvar i = 0; i < N_BTNS; i++) begin : g_chan
        btn_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_REPEAT_EN
            ,
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
        ) u_chan (
            .clk_50M    (clk_50M),
            .rst_b      (rst_b),
            .btn_b      (btns_b[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

endmodule
